add_accumulator: RTL and testbench

ADD_ACCUMULATOR -- requirements
Module: add_accumulator

---
 rtl/add_acc_pkg.sv | 23 ++
 rtl/add_accumulator_if.sv | 44 ++++
 rtl/add_accumulator_rise_detect.sv | 33 +++
 rtl/add_accumulator.sv | 110 +++++++++++
 tb/tb_add_accumulator.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/add_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : add_acc_pkg
// Purpose  : Shared definitions for the add/accumulate datapath controller:
//            default operand width and the controller state enumeration.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package add_acc_pkg;

    // Default operand / accumulator width in bits.
    localparam int DEFAULT_WIDTH = 16;

    // Controller states. Encodings are fixed so that the top level can
    // mirror them as plain 2-bit constants.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } acc_state_e;

endpackage : add_acc_pkg
`default_nettype wire

// File: rtl/add_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module   : add_accumulator_if
// Purpose  : Bundles the control inputs, the external-adder operand/result
//            bus and the status outputs of add_accumulator.
// Signals  : run, cleara_loadb, sw      - control / operand from environment
//            add_a, add_b, add_cin      - operands towards external adder
//            add_s, add_cout            - result from external adder
//            acc, carry, ovf, busy, done- status towards environment
// Modports : master - environment side (drives controls and adder result)
//            slave  - accumulator side (add_accumulator)
// Revision : 1.0 - initial release
// ============================================================================
interface add_accumulator_if
    import add_acc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             run;
    logic             cleara_loadb;
    logic [WIDTH-1:0] sw;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_s;
    logic             add_cout;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic             ovf;
    logic             busy;
    logic             done;

    modport master (
        output run, cleara_loadb, sw, add_s, add_cout,
        input  add_a, add_b, add_cin, acc, carry, ovf, busy, done
    );

    modport slave (
        input  run, cleara_loadb, sw, add_s, add_cout,
        output add_a, add_b, add_cin, acc, carry, ovf, busy, done
    );

endinterface : add_accumulator_if
`default_nettype wire

// File: rtl/add_accumulator_rise_detect.sv
`default_nettype none
// ============================================================================
// Module   : rise_detect
// Purpose  : Single-cycle rising-edge detector for a synchronous level.
//            The previous-value register resets to 1 so that a level that is
//            already high when reset releases does not register as an edge.
// Ports    : clk     - clock
//            rst     - synchronous active-high reset
//            i_level - synchronous level input
//            o_rise  - high in the cycle where i_level=1 and was 0 last cycle
// Revision : 1.0 - initial release
// ============================================================================
module rise_detect (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_level,
    output logic      o_rise
);

    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= i_level;
        end
    end

    assign o_rise = i_level & ~r_prev;

endmodule : rise_detect
`default_nettype wire

// File: rtl/add_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : add_accumulator
// Purpose  : Accumulator controller around an external combinational adder.
//            A rising edge of run adds the B register to the accumulator
//            (IDLE -> ADD -> DONE -> IDLE); cleara_loadb in IDLE clears the
//            accumulator and loads B from sw.
// Ports    : clk  - clock, all state on rising edge
//            rst  - synchronous active-high reset
//            bus  - add_accumulator_if.slave (controls, adder bus, status)
// Config   : ADD_ACC_OVF_EN - when defined, ovf captures signed overflow of
//            each add; otherwise ovf is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module add_accumulator
    import add_acc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
)(
    input  wire logic          clk,
    input  wire logic          rst,
    add_accumulator_if.slave   bus
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_ADD  = ADD;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic             w_run_rise;
    logic             w_clear;

    rise_detect u_rise_detect (
        .clk     (clk),
        .rst     (rst),
        .i_level (bus.run),
        .o_rise  (w_run_rise)
    );

    // Clear/load only acts in IDLE; it also takes priority over a run edge.
    assign w_clear = (r_state == ST_IDLE) && bus.cleara_loadb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.cleara_loadb) begin
                        r_acc   <= '0;
                        r_b     <= bus.sw;
                        r_carry <= 1'b0;
                    end else if (w_run_rise) begin
                        r_state <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    r_acc   <= bus.add_s;
                    r_carry <= bus.add_cout;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ADD_ACC_OVF_EN
    logic r_ovf;
    logic w_ovf_term;

    // Signed overflow: operands share a sign but the sum's sign differs.
    assign w_ovf_term = (r_acc[WIDTH-1] == r_b[WIDTH-1]) &&
                        (bus.add_s[WIDTH-1] != r_acc[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_clear) begin
            r_ovf <= 1'b0;
        end else if (r_state == ST_ADD) begin
            r_ovf <= w_ovf_term;
        end
    end

    assign bus.ovf = r_ovf;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.add_a   = r_acc;
    assign bus.add_b   = r_b;
    assign bus.add_cin = 1'b0;
    assign bus.acc     = r_acc;
    assign bus.carry   = r_carry;
    assign bus.busy    = (r_state != ST_IDLE);
    assign bus.done    = (r_state == ST_DONE);

endmodule : add_accumulator
`default_nettype wire

// File: tb/tb_add_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_accumulator
// Purpose  : Self-checking bench for add_accumulator. Provides the external
//            adder, drives directed and random sequences, and compares the
//            outputs against an arithmetic model of the accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_add_accumulator;
    import add_acc_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;

    add_accumulator_if #(.WIDTH(W)) bus ();

    add_accumulator #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // External adder: plain WIDTH+1-bit addition.
    logic [W:0] w_sum_full;
    assign w_sum_full   = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{W{1'b0}}, bus.add_cin};
    assign bus.add_s    = w_sum_full[W-1:0];
    assign bus.add_cout = w_sum_full[W];

    always #5 clk = ~clk;

    // Reference model state.
    int unsigned m_acc;
    int unsigned m_b;
    int unsigned m_carry;
    int unsigned m_ovf;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; land 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int to_signed(input int unsigned v);
        return (v >= 32768) ? int'(v) - 65536 : int'(v);
    endfunction

    task automatic model_add();
        int unsigned s;
        int          ss;
        s  = m_acc + m_b;
        ss = to_signed(m_acc) + to_signed(m_b);
        m_carry = (s >= 65536) ? 1 : 0;
        m_acc   = s % 65536;
`ifdef ADD_ACC_OVF_EN
        m_ovf = (ss > 32767 || ss < -32768) ? 1 : 0;
`else
        m_ovf = 0;
`endif
    endtask

    task automatic load(input int unsigned val);
        bus.sw           = W'(val);
        bus.cleara_loadb = 1'b1;
        tick();
        bus.cleara_loadb = 1'b0;
        m_acc = 0; m_b = val; m_carry = 0; m_ovf = 0;
        check("load_acc",   32'(bus.acc),   m_acc);
        check("load_b",     32'(bus.add_b), m_b);
        check("load_carry", 32'(bus.carry), m_carry);
        check("load_ovf",   32'(bus.ovf),   m_ovf);
    endtask

    // One add via a run pulse; expects run=0 history on entry.
    task automatic do_add(input string tag);
        bus.run = 1'b1;
        check({tag, "_busy_pre"}, 32'(bus.busy), 0);
        tick();
        check({tag, "_busy_add"}, 32'(bus.busy), 1);
        check({tag, "_done_add"}, 32'(bus.done), 0);
        tick();
        model_add();
        check({tag, "_acc"},   32'(bus.acc),   m_acc);
        check({tag, "_add_a"}, 32'(bus.add_a), m_acc);
        check({tag, "_carry"}, 32'(bus.carry), m_carry);
        check({tag, "_ovf"},   32'(bus.ovf),   m_ovf);
        check({tag, "_done"},  32'(bus.done),  1);
        tick();
        check({tag, "_done_end"}, 32'(bus.done), 0);
        check({tag, "_busy_end"}, 32'(bus.busy), 0);
        bus.run = 1'b0;
        tick();
    endtask

    initial begin
        int dones;
        rst = 1'b1;
        bus.run = 1'b0;
        bus.cleara_loadb = 1'b0;
        bus.sw = '0;
        m_acc = 0; m_b = 0; m_carry = 0; m_ovf = 0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_acc",   32'(bus.acc),     0);
        check("rst_busy",  32'(bus.busy),    0);
        check("rst_done",  32'(bus.done),    0);
        check("rst_carry", 32'(bus.carry),   0);
        check("rst_ovf",   32'(bus.ovf),     0);
        check("rst_b",     32'(bus.add_b),   0);
        check("cin_zero",  32'(bus.add_cin), 0);
        tick();

        // Basic adds: 0x45 then 0x8A.
        load(32'h45);
        do_add("add45");
        check("acc_0045", 32'(bus.acc), 32'h0045);
        do_add("add8a");
        check("acc_008a", 32'(bus.acc), 32'h008A);

        // Wrap with carry-out, no signed overflow (negative + negative).
        load(32'hFFF1);
        do_add("fff1_a");
        do_add("fff1_b");
        check("wrap_acc",   32'(bus.acc),   32'hFFE2);
        check("wrap_carry", 32'(bus.carry), 1);
        check("wrap_ovf",   32'(bus.ovf),   0);

        // Signed overflow: 0x4000 + 0x4000.
        load(32'h4000);
        do_add("ovf_a");
        do_add("ovf_b");
        check("ovf_acc", 32'(bus.acc), 32'h8000);
`ifdef ADD_ACC_OVF_EN
        check("ovf_flag", 32'(bus.ovf), 1);
`else
        check("ovf_flag", 32'(bus.ovf), 0);
`endif

        // Run held high: exactly one add.
        load(32'h0021);
        bus.run = 1'b1;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.done === 1'b1) dones++;
        end
        bus.run = 1'b0;
        model_add();
        check("held_dones", 32'(dones), 1);
        check("held_acc",   32'(bus.acc), m_acc);
        tick();

        // Clear/load together with run edge: clear wins, no add.
        bus.sw = 16'h1234;
        bus.cleara_loadb = 1'b1;
        bus.run = 1'b1;
        tick();
        bus.cleara_loadb = 1'b0;
        m_acc = 0; m_b = 32'h1234; m_carry = 0; m_ovf = 0;
        check("clr_run_acc",  32'(bus.acc),   0);
        check("clr_run_b",    32'(bus.add_b), 32'h1234);
        check("clr_run_busy", 32'(bus.busy),  0);
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
        end
        check("clr_run_noadd", 32'(dones), 0);
        check("clr_run_acc2",  32'(bus.acc), 0);
        bus.run = 1'b0;
        tick();

        // Clear/load ignored while busy.
        load(32'h0011);
        bus.run = 1'b1;
        tick();
        bus.sw = 16'hBEEF;
        bus.cleara_loadb = 1'b1;
        tick();
        bus.cleara_loadb = 1'b0;
        model_add();
        check("busy_clr_acc", 32'(bus.acc),   m_acc);
        check("busy_clr_b",   32'(bus.add_b), m_b);
        tick();
        bus.run = 1'b0;
        tick();

        // Reset during ADD aborts the add.
        bus.run = 1'b1;
        tick();
        check("abort_busy_pre", 32'(bus.busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_acc = 0; m_b = 0; m_carry = 0; m_ovf = 0;
        check("abort_acc",  32'(bus.acc),   0);
        check("abort_done", 32'(bus.done),  0);
        check("abort_busy", 32'(bus.busy),  0);
        check("abort_b",    32'(bus.add_b), 0);
        tick();
        check("abort_done2", 32'(bus.done), 0);
        check("abort_acc2",  32'(bus.acc),  0);
        bus.run = 1'b0;
        tick();

        // Random sequence of loads and adds.
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                load($urandom_range(0, 65535));
            end
            do_add("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_add_accumulator
`default_nettype wire
